module_spi_slave_ctrl: RTL and testbench
========================================

// Module: module_spi_slave_ctrl
// PURPOSE
//  SPI responder (slave), mode 0 (CPOL=0/CPHA=0), 8-bit frames, MSB first. Oversamples SCLK/CS_N/MOSI on clk_i,
//  stores each received byte into the data register bank at consecutive addresses from 0, and shifts out per-byte
//  TX data read from the same bank. Counterpart of the SPI master control FSM; used for loopback/board-to-board links.
// PARAMETERS
//  N  32  register bank depth (bytes per frame before overflow)
// PORTS
//  clk_i        in   1               system clock, 10 MHz
//  reset_i      in   1               synchronous, active-high reset
//  sclk_i       in   1               SPI clock from master (async)
//  cs_n_i       in   1               SPI chip select, active low (async)
//  mosi_i       in   1               master-out data (async)
//  miso_o       out  1               slave-out data
//  miso_oe_o    out  1               MISO output enable (1 only while selected)
//  tx_data_i    in   8               bank read data at addr_o (valid same cycle as addr_o)
//  addr_o       out  $clog2(N)       bank address for current byte (write and TX read)
//  wr_o         out  1               one-cycle bank write strobe
//  data_o       out  32              write data = {24'b0, rx byte}
//  n_o          out  $clog2(N)+1     bytes received in current/last frame
//  busy_o       out  1               1 while frame active (state != IDLE)
//  overflow_o   out  1               sticky: frame exceeded N bytes; cleared at next frame start
//  done_o       out  1               one-cycle pulse at frame end (CS_N rise)
// BEHAVIOUR
//  Sync: sclk_i, cs_n_i, mosi_i through 2-FF synchronizers + 1 history FF; edges detected on synced signals
//   (2-3 clk latency). Constraint: SCLK <= clk_i/8; master waits >= 4 clk from CS_N fall to first SCLK rise.
//  Reset: all outputs 0, miso_oe_o=0, state IDLE, shift regs/bit_cnt 0.
//  States: IDLE, LOAD, SHIFT, STORE, DONE.
//  IDLE : waits for synced CS_N falling edge (a level-low CS_N alone never starts a frame) ->
//         n_o<=0, addr_o<=0, overflow_o<=0, busy_o<=1 -> LOAD.
//  LOAD : 1 cycle; tx_sr<=tx_data_i (8'h00 if n_o==N); miso_o<=MSB; miso_oe_o<=1; bit_cnt<=0 -> SHIFT.
//  SHIFT: SCLK rise: rx_sr<={rx_sr[6:0],mosi_sync}, bit_cnt++. SCLK fall with bit_cnt in 1..7: tx_sr<<1,
//         miso_o<=next bit. bit_cnt reaching 8 -> STORE. CS_N rise with bit_cnt<8 -> DONE (partial byte dropped).
//  STORE: 1 cycle. If n_o<N: wr_o=1, addr_o=n_o[..], data_o={24'b0,rx_sr}, n_o++; then addr_o<=n_o+1
//         (held at N-1 max). If n_o==N: no write, overflow_o<=1. -> LOAD (or DONE if CS_N rise pending).
//  DONE : done_o=1 one cycle, miso_oe_o<=0, miso_o<=0, busy_o<=0 -> IDLE. n_o, overflow_o hold until next frame.
//  Simultaneous 8th SCLK rise and CS_N rise: byte completes (STORE performed), then DONE.
//  wr_o, done_o are single-cycle pulses; never asserted together. addr_o never exceeds N-1.
//  Reset mid-frame: immediate return to IDLE, no write; frame restarts only on a new CS_N fall.
// TESTING
//  1 Reset asserted with random inputs -> all outputs 0, miso_oe_o=0, state IDLE.
//  2 1-byte frame, MOSI 0xA5, bank[0]=0x3C -> wr_o once addr 0 data 0x000000A5; master reads 0x3C; n_o=1; done_o pulse.
//  3 3-byte frame MOSI 01,02,03, bank TX 10,20,30 -> writes addr 0,1,2; MISO 10,20,30; n_o=3; overflow_o=0.
//  4 CS_N rise after 5 SCLK edges -> no wr_o, n_o=0, done_o pulse, miso_oe_o=0.
//  5 N=4, 5-byte frame -> 4 writes addr 0..3, 5th MISO byte 0x00, overflow_o=1, n_o=4; cleared at next CS_N fall.
//  6 reset_i mid-byte with CS_N held low -> no writes, busy_o=0 until CS_N toggles high then low.

Source files
------------

// File: rtl/module_spi_slave_ctrl.sv
// SPI mode-0 responder: 8-bit MSB-first frames, RX bytes written to a
// register bank at consecutive addresses, TX bytes read from the same bank.
module module_spi_slave_ctrl #(
    parameter int N = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 sclk_i,
    input  logic                 cs_n_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    output logic                 miso_oe_o,
    input  logic [7:0]           tx_data_i,
    output logic [$clog2(N)-1:0] addr_o,
    output logic                 wr_o,
    output logic [31:0]          data_o,
    output logic [$clog2(N):0]   n_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic                 done_o
);

    localparam int AW = $clog2(N);
    localparam int NW = AW + 1;
    localparam logic [NW-1:0] NMAX = NW'(N);
    localparam logic [AW-1:0] AMAX = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_sclk_s;
    logic [2:0]    r_cs_s;
    logic [1:0]    r_mosi_s;
    logic [7:0]    r_tx_sr;
    logic [7:0]    r_rx_sr;
    logic [3:0]    r_bit_cnt;
    logic [NW-1:0] r_n;
    logic [AW-1:0] r_addr;
    logic          r_ovf;
    logic          r_busy;
    logic          r_oe;
    logic          r_cs_pend;

    logic          w_sclk_rise;
    logic          w_sclk_fall;
    logic          w_cs_rise;
    logic          w_cs_fall;
    logic          w_cs_end;
    logic          w_full;
    logic [NW-1:0] w_n_inc;
    logic [7:0]    w_tx_ld;

    // [0],[1] synchronize, [2] is the edge-detect history
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sclk_s <= '0;
            r_cs_s   <= '0;
            r_mosi_s <= '0;
        end else begin
            r_sclk_s <= {r_sclk_s[1:0], sclk_i};
            r_cs_s   <= {r_cs_s[1:0], cs_n_i};
            r_mosi_s <= {r_mosi_s[0], mosi_i};
        end
    end

    assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
    assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
    assign w_cs_rise   = r_cs_s[1] & ~r_cs_s[2];
    assign w_cs_fall   = ~r_cs_s[1] & r_cs_s[2];
    assign w_cs_end    = w_cs_rise | r_cs_pend;
    assign w_full      = (r_n == NMAX);
    assign w_n_inc     = r_n + NW'(1);
    assign w_tx_ld     = w_full ? 8'h00 : tx_data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        wr_o   = 1'b0;
        data_o = 32'h0;
        done_o = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_sclk_rise && r_bit_cnt == 4'd7) begin
                    w_next = S_STORE;
                end else if (w_cs_end) begin
                    w_next = S_DONE;
                end
            end
            S_STORE: begin
                wr_o   = ~w_full;
                data_o = w_full ? 32'h0 : {24'h0, r_rx_sr};
                w_next = w_cs_end ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
            r_n       <= '0;
            r_addr    <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_oe      <= 1'b0;
            r_cs_pend <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_state == S_DONE) begin
                r_cs_pend <= 1'b0;
            end else if (w_cs_rise) begin
                r_cs_pend <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_n    <= '0;
                        r_addr <= '0;
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_tx_sr   <= w_tx_ld;
                    r_oe      <= 1'b1;
                    r_bit_cnt <= '0;
                end
                S_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_rx_sr   <= {r_rx_sr[6:0], r_mosi_s[1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else if (w_sclk_fall && r_bit_cnt != 4'd0 &&
                                 r_bit_cnt < 4'd8) begin
                        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                    end
                end
                S_STORE: begin
                    if (!w_full) begin
                        r_n    <= w_n_inc;
                        r_addr <= (w_n_inc >= NMAX) ? AMAX : w_n_inc[AW-1:0];
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_tx_sr <= '0;
                    r_oe    <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // MISO is always the shift register MSB; cleared outside a frame
    assign miso_o     = r_tx_sr[7];
    assign miso_oe_o  = r_oe;
    assign addr_o     = r_addr;
    assign n_o        = r_n;
    assign busy_o     = r_busy;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_module_spi_slave_ctrl.sv
// Directed bench for the SPI responder: acts as SPI master and register bank.
module tb_module_spi_slave_ctrl;

    localparam int N = 4;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [7:0]  tx_data;
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] data;
    logic [2:0]  n;
    logic        busy;
    logic        ovf;
    logic        done;

    logic [7:0]  bank_tx [N];
    logic [1:0]  wa_q [$];
    logic [31:0] wd_q [$];
    int          done_cnt = 0;
    int          clash_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #50 clk = ~clk;

    assign tx_data = bank_tx[addr];

    module_spi_slave_ctrl #(.N(N)) dut (
        .clk_i(clk), .reset_i(reset), .sclk_i(sclk), .cs_n_i(cs_n),
        .mosi_i(mosi), .miso_o(miso), .miso_oe_o(miso_oe),
        .tx_data_i(tx_data), .addr_o(addr), .wr_o(wr), .data_o(data),
        .n_o(n), .busy_o(busy), .overflow_o(ovf), .done_o(done)
    );

    always @(negedge clk) begin
        if (wr === 1'b1) begin
            wa_q.push_back(addr);
            wd_q.push_back(data);
        end
        if (done === 1'b1) done_cnt++;
        if (wr === 1'b1 && done === 1'b1) clash_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_clk(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_end();
        wait_clk(H);
        cs_n = 1'b1;
        wait_clk(12);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            wait_clk(H);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            wait_clk(H);
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [47:0] obs;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sclk = 1'($urandom_range(1));
            cs_n = 1'($urandom_range(1));
            mosi = 1'($urandom_range(1));
            @(negedge clk);
            obs = {miso, miso_oe, addr, wr, data, n, busy, ovf, done, 5'b0};
            checks++;
            if (obs !== 48'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d got %h want 0", c, obs);
            end
        end
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        reset = 1'b0;
        wait_clk(6);
        checks++;
        if (busy !== 1'b0 || miso_oe !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL post_reset_idle busy %b oe %b done %0d want 0",
                     busy, miso_oe, done_cnt);
        end
    endtask

    task automatic test_one_byte();
        logic [7:0] rx;
        int d0;
        bank_tx[0] = 8'h3C;
        clear_log();
        d0 = done_cnt;
        cs_start();
        checks++;
        if (busy !== 1'b1 || miso_oe !== 1'b1) begin
            errors++;
            $display("FAIL one_active busy %b oe %b want 1 1", busy, miso_oe);
        end
        spi_xfer(8'hA5, rx);
        cs_end();
        checks++;
        if (wa_q.size() != 1) begin
            errors++;
            $display("FAIL one_wr_count got %0d want 1", wa_q.size());
        end else if (wa_q[0] !== 2'd0 || wd_q[0] !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL one_wr got a%0d d%h want a0 d000000a5",
                     wa_q[0], wd_q[0]);
        end
        checks++;
        if (rx !== 8'h3C) begin
            errors++;
            $display("FAIL one_miso got %h want 3c", rx);
        end
        checks++;
        if (n !== 3'd1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL one_end n %0d done %0d want 1 1", n, done_cnt - d0);
        end
        checks++;
        if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL one_idle busy %b oe %b miso %b want 0",
                     busy, miso_oe, miso);
        end
    endtask

    task automatic test_three_bytes();
        logic [7:0] rx;
        logic [7:0] txv [3];
        logic [7:0] mv [3];
        txv = '{8'h10, 8'h20, 8'h30};
        mv  = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 3; i++) bank_tx[i] = txv[i];
        clear_log();
        cs_start();
        for (int b = 0; b < 3; b++) begin
            spi_xfer(mv[b], rx);
            checks++;
            if (rx !== txv[b]) begin
                errors++;
                $display("FAIL three_miso b%0d got %h want %h", b, rx, txv[b]);
            end
        end
        cs_end();
        checks++;
        if (wa_q.size() != 3) begin
            errors++;
            $display("FAIL three_wr_count got %0d want 3", wa_q.size());
        end else begin
            for (int b = 0; b < 3; b++) begin
                checks++;
                if (wa_q[b] !== 2'(b) || wd_q[b] !== {24'h0, mv[b]}) begin
                    errors++;
                    $display("FAIL three_wr b%0d got a%0d d%h want a%0d d%h",
                             b, wa_q[b], wd_q[b], b, {24'h0, mv[b]});
                end
            end
        end
        checks++;
        if (n !== 3'd3 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL three_end n %0d ovf %b want 3 0", n, ovf);
        end
    endtask

    task automatic test_partial();
        int d0;
        clear_log();
        d0 = done_cnt;
        cs_start();
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1;
            wait_clk(H);
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
        cs_end();
        checks++;
        if (wa_q.size() != 0 || n !== 3'd0) begin
            errors++;
            $display("FAIL partial_nowr writes %0d n %0d want 0 0",
                     wa_q.size(), n);
        end
        checks++;
        if (done_cnt - d0 != 1 || miso_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL partial_done done %0d oe %b busy %b want 1 0 0",
                     done_cnt - d0, miso_oe, busy);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] rx;
        logic [7:0] txv [4];
        logic [7:0] want;
        txv = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) bank_tx[i] = txv[i];
        clear_log();
        cs_start();
        for (int b = 0; b < 5; b++) begin
            spi_xfer(8'hA1 + 8'(b), rx);
            want = (b < 4) ? txv[b] : 8'h00;
            checks++;
            if (rx !== want) begin
                errors++;
                $display("FAIL ovf_miso b%0d got %h want %h", b, rx, want);
            end
        end
        cs_end();
        checks++;
        if (wa_q.size() != 4) begin
            errors++;
            $display("FAIL ovf_wr_count got %0d want 4", wa_q.size());
        end else begin
            for (int b = 0; b < 4; b++) begin
                checks++;
                if (wa_q[b] !== 2'(b) || wd_q[b] !== 32'(8'hA1 + 8'(b))) begin
                    errors++;
                    $display("FAIL ovf_wr b%0d got a%0d d%h", b, wa_q[b], wd_q[b]);
                end
            end
        end
        checks++;
        if (ovf !== 1'b1 || n !== 3'd4) begin
            errors++;
            $display("FAIL ovf_flag ovf %b n %0d want 1 4", ovf, n);
        end
        cs_start();
        checks++;
        if (ovf !== 1'b0 || n !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear ovf %b n %0d busy %b want 0 0 1",
                     ovf, n, busy);
        end
        cs_end();
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        bank_tx[0] = 8'h96;
        clear_log();
        cs_start();
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b0;
            wait_clk(H);
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_clk(H);
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
        wait_clk(4);
        checks++;
        if (busy !== 1'b0 || miso_oe !== 1'b0 || wa_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_idle busy %b oe %b writes %0d want 0 0 0",
                     busy, miso_oe, wa_q.size());
        end
        cs_n = 1'b1;
        wait_clk(10);
        cs_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart busy %b want 1", busy);
        end
        spi_xfer(8'h5A, rx);
        cs_end();
        checks++;
        if (wa_q.size() != 1 || rx !== 8'h96 || n !== 3'd1) begin
            errors++;
            $display("FAIL rstmid_frame writes %0d rx %h n %0d want 1 96 1",
                     wa_q.size(), rx, n);
        end else if (wd_q[0] !== 32'h5A) begin
            errors++;
            $display("FAIL rstmid_data got %h want 0000005a", wd_q[0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        for (int i = 0; i < N; i++) bank_tx[i] = 8'h00;
        test_reset();
        test_one_byte();
        test_three_bytes();
        test_partial();
        test_overflow();
        test_reset_mid();
        checks++;
        if (clash_cnt != 0) begin
            errors++;
            $display("FAIL wr_done_clash got %0d want 0", clash_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
